memory_stage: RTL and testbench
===============================

# memory_stage

Memory (M) stage of the pipelined Y86-64 core. Consumes the M pipeline register outputs and performs the data-memory access for rmmovq, mrmovq, pushq, popq, call and ret over a request/response bus. Produces valM and the final stage status for the W register. It stalls the pipeline through `m_busy_o` until the access finishes, errors or times out.

## Interface
- `MEM_BYTES`, default 65536: bytes of valid data address space; addr + 8 > MEM_BYTES is an address error.
- `TIMEOUT`, default 255: maximum cycles allowed in REQ+RESP before the access is aborted with SADR.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `M_stat_i`, `M_icode_i`, `M_valE_i`, `M_valA_i` in `STAT_BUS`/`ICODE_BUS`/`DATA_BUS`/`DATA_BUS`: M register contents.
- `M_stall_i` in 1: the M register is held this cycle by pipeline control, for any reason.
- `mem_req_o` out 1: request valid.
- `mem_we_o` out 1: 1 = write 8 bytes, 0 = read 8 bytes.
- `mem_addr_o` out `ADDR_BUS`: byte address.
- `mem_wdata_o` out `DATA_BUS`: write data.
- `mem_ready_i` in 1: request accepted when high together with `mem_req_o`.
- `mem_rvalid_i` in 1: response or write acknowledge.
- `mem_rdata_i` in `DATA_BUS`: read data, valid with `mem_rvalid_i`.
- `mem_err_i` in 1: bus error, valid with `mem_rvalid_i`.
- `m_valM_o` out `DATA_BUS`: loaded value.
- `m_stat_o` out `STAT_BUS`: status toward W.
- `m_busy_o` out 1: access in progress; control stalls F/D/E/M and bubbles W.

## Operation
- Access decode:
  - Read at valE: mrmovq.
  - Read at valA: popq, ret.
  - Write valA at valE: rmmovq, pushq, call.
  - All other icodes and `M_stat_i != SAOK` do no access.
- No-access instructions:
  - Combinational pass-through: `m_stat_o = M_stat_i`, `m_valM_o = 0`, `m_busy_o = 0`.
- Out-of-range address:
  - No bus request.
  - Goes to DONE with `m_stat_o = SADR`.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: an access instruction is present → `m_busy_o = 1` combinationally. Next state is REQ, or DONE for an out-of-range address.
  - REQ: `mem_req_o = 1`. addr, we and wdata are registered and held stable until `mem_ready_i`. The accept cycle moves to RESP.
  - RESP: wait for `mem_rvalid_i`, then latch rdata/err and move to DONE. `mem_rvalid_i` arriving in the same cycle as accept is legal; go straight to DONE.
  - DONE: `m_busy_o = 0`. Drive the latched valM and stat: SADR on err or timeout, else `M_stat_i`. Stay while `M_stall_i = 1`; leave to IDLE on the first cycle with `M_stall_i = 0`, when the M register advances.
- Timeout: a counter runs in REQ+RESP. On reaching TIMEOUT, drop `mem_req_o` and go to DONE with SADR and `valM = 0`.
- `mem_rvalid_i` in IDLE or DONE is ignored. These are stale responses after reset or abort.
- Writes return `valM = 0`.

## Timing
- Reset, and the first cycle after it:
  - State IDLE, counter 0.
  - `mem_req_o = 0`, `mem_we_o = 0`, `mem_addr_o = 0`, `mem_wdata_o = 0`.
  - Latched valM and err are 0.
  - `m_busy_o = 0` while `rst_i` is high.
- Reset mid-access drops `mem_req_o` next edge with no completion.
- Best-case access: instruction in M at cycle 0 (busy), REQ at cycle 1 with ready, rvalid at cycle 2, DONE at cycle 3 (busy low). M advances at the end of cycle 3. Four cycles in M total.
- Each wait cycle on ready or rvalid adds one cycle.
- No-access instructions spend one cycle in M.

## Structure
- Add to `define.v`:
  - `SAOK`/`SADR` stat codes.
  - Memory icode constants, already present for the other stages.
  - The 2-bit state encoding `MST_IDLE`..`MST_DONE`.
- Single module; access decode is a local combinational block. No sub-module.

## Test plan
- Test 1: mrmovq, valE=0x100, ready and rvalid immediate, rdata=0xDEADBEEF.
  - Expect addr 0x100 and we=0.
  - Expect busy for cycles 0–2.
  - In DONE expect valM=0xDEADBEEF and stat=SAOK.
- Test 2: pushq with valE=0x1F8, valA=0x55, ready delayed 3 cycles.
  - Expect req held with addr and wdata stable.
  - Expect we=1 and exactly one accept.
  - Expect valM=0.
- Test 3: mrmovq with valE=0xFFFC at MEM_BYTES=65536.
  - Expect no `mem_req_o`.
  - Expect DONE at cycle 1 with stat=SADR.
- Test 4: popq where rvalid never comes, TIMEOUT=4.
  - Expect req/resp for 4 cycles, then DONE with SADR and req low.
  - A late rvalid afterwards is ignored.
- Test 5: DONE with `M_stall_i` high for 2 cycles.
  - Expect valM held for those 2 cycles with no second request.
  - The next instruction starts a fresh access.
- Test 6: rst_i asserted in RESP.
  - Expect IDLE and busy=0.
  - A following rvalid with err=1 does not affect the next nop, which gets stat=SAOK.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the Y86-64 memory stage: bus widths, status codes, icodes, FSM states.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package memory_stage_pkg;

   localparam int STAT_W  = 3;
   localparam int ICODE_W = 4;
   localparam int DATA_W  = 64;
   localparam int ADDR_W  = 64;

   typedef logic [STAT_W-1:0]  stat_t;
   typedef logic [ICODE_W-1:0] icode_t;

   // Y86-64 status codes
   localparam stat_t SAOK = 3'd1;
   localparam stat_t SHLT = 3'd2;
   localparam stat_t SADR = 3'd3;
   localparam stat_t SINS = 3'd4;

   // Y86-64 instruction codes
   localparam icode_t IHALT   = 4'h0;
   localparam icode_t INOP    = 4'h1;
   localparam icode_t IRRMOVQ = 4'h2;
   localparam icode_t IIRMOVQ = 4'h3;
   localparam icode_t IRMMOVQ = 4'h4;
   localparam icode_t IMRMOVQ = 4'h5;
   localparam icode_t IOPQ    = 4'h6;
   localparam icode_t IJXX    = 4'h7;
   localparam icode_t ICALL   = 4'h8;
   localparam icode_t IRET    = 4'h9;
   localparam icode_t IPUSHQ  = 4'hA;
   localparam icode_t IPOPQ   = 4'hB;

   // Memory-access FSM states
   typedef enum logic [1:0] {
      MST_IDLE = 2'd0,
      MST_REQ  = 2'd1,
      MST_RESP = 2'd2,
      MST_DONE = 2'd3
   } mst_e;

   // Decoded data-memory access for the instruction sitting in M
   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } acc_t;

endpackage

// File: rtl/memory_stage.sv
// Y86-64 M stage: decodes the data access, runs it over the req/resp bus, produces valM and stat for W.
// Latency: no-access instr 1 cycle in M; access = 1 + REQ/RESP cycles + 1 DONE (best case 4), addr error 2.
// Backpressure: holds mem_req_o with stable addr/we/wdata until mem_ready_i; m_busy_o stalls the pipe until DONE.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int MEM_BYTES = 65536,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [STAT_W-1:0] M_stat_i,
   input  logic [ICODE_W-1:0] M_icode_i,
   input  logic [DATA_W-1:0] M_valE_i,
   input  logic [DATA_W-1:0] M_valA_i,
   input  logic              M_stall_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_err_i,
   output logic [DATA_W-1:0] m_valM_o,
   output logic [STAT_W-1:0] m_stat_o,
   output logic              m_busy_o
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mst_e              state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] valm_q;
   logic              err_q;

   acc_t              acc;
   logic              do_access;
   logic              addr_oob;
   logic [ADDR_W:0]   addr_end;
   logic              cnt_last;

   // Access decode: which bus operation the instruction in M needs, and where
   always_comb begin
      acc = '0;
      if (M_stat_i == SAOK) begin
         case (M_icode_i)
            IMRMOVQ: begin
               acc.rd   = 1'b1;
               acc.addr = M_valE_i;
            end
            IPOPQ, IRET: begin
               acc.rd   = 1'b1;
               acc.addr = M_valA_i;
            end
            IRMMOVQ, IPUSHQ, ICALL: begin
               acc.wr    = 1'b1;
               acc.addr  = M_valE_i;
               acc.wdata = M_valA_i;
            end
            default: ;
         endcase
      end
   end

   // One extra bit keeps addr + 8 from wrapping for addresses near 2^64
   assign addr_end  = {1'b0, acc.addr} + (ADDR_W+1)'(8);
   assign addr_oob  = addr_end > (ADDR_W+1)'(MEM_BYTES);
   assign do_access = acc.rd | acc.wr;
   assign cnt_last  = (cnt_q == CNT_LAST);

   // Access FSM with registered bus outputs; responses outside REQ/RESP are dropped
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= MST_IDLE;
         cnt_q       <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         valm_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            MST_IDLE: begin
               if (do_access) begin
                  if (addr_oob) begin
                     state_q <= MST_DONE;
                     err_q   <= 1'b1;
                     valm_q  <= '0;
                  end else begin
                     state_q     <= MST_REQ;
                     cnt_q       <= '0;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= acc.wr;
                     mem_addr_o  <= acc.addr;
                     mem_wdata_o <= acc.wdata;
                  end
               end
            end
            MST_REQ: begin
               if (mem_ready_i && mem_rvalid_i) begin
                  mem_req_o <= 1'b0;
                  state_q   <= MST_DONE;
                  valm_q    <= mem_we_o ? '0 : mem_rdata_i;
                  err_q     <= mem_err_i;
               end else if (cnt_last) begin
                  mem_req_o <= 1'b0;
                  state_q   <= MST_DONE;
                  valm_q    <= '0;
                  err_q     <= 1'b1;
               end else if (mem_ready_i) begin
                  mem_req_o <= 1'b0;
                  state_q   <= MST_RESP;
                  cnt_q     <= cnt_q + CNT_W'(1);
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            MST_RESP: begin
               if (mem_rvalid_i) begin
                  state_q <= MST_DONE;
                  valm_q  <= mem_we_o ? '0 : mem_rdata_i;
                  err_q   <= mem_err_i;
               end else if (cnt_last) begin
                  state_q <= MST_DONE;
                  valm_q  <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            MST_DONE: begin
               if (!M_stall_i) begin
                  state_q <= MST_IDLE;
                  valm_q  <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: state_q <= MST_IDLE;
         endcase
      end
   end

   // Stage outputs: pass-through unless an access owns the stage
   always_comb begin
      m_stat_o = M_stat_i;
      m_valM_o = '0;
      m_busy_o = 1'b0;
      case (state_q)
         MST_IDLE: m_busy_o = do_access;
         MST_REQ,
         MST_RESP: m_busy_o = 1'b1;
         MST_DONE: begin
            m_valM_o = valm_q;
            m_stat_o = err_q ? SADR : M_stat_i;
         end
         default: ;
      endcase
      if (rst_i) begin
         m_busy_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized instructions vs a transaction-level model.
// Latency: the model predicts busy cycles, request cycles, accepts and the DONE result per instruction.
// Backpressure: a bench-side responder applies per-instruction ready and rvalid delays.
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int MEM_BYTES = 65536;
   localparam int TIMEOUT   = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [STAT_W-1:0] M_stat_i;
   logic [ICODE_W-1:0] M_icode_i;
   logic [DATA_W-1:0] M_valE_i;
   logic [DATA_W-1:0] M_valA_i;
   logic              M_stall_i;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ready_i;
   logic              mem_rvalid_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_err_i;
   logic [DATA_W-1:0] m_valM_o;
   logic [STAT_W-1:0] m_stat_o;
   logic              m_busy_o;

   int n_chk = 0;
   int n_err = 0;

   memory_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .M_stat_i(M_stat_i), .M_icode_i(M_icode_i), .M_valE_i(M_valE_i), .M_valA_i(M_valA_i),
      .M_stall_i(M_stall_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .m_valM_o(m_valM_o), .m_stat_o(m_stat_o), .m_busy_o(m_busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction in M and follow it until it leaves M.
   // d_r: request cycles refused before ready; d_v: cycles from accept to rvalid (0 = same cycle).
   task automatic run_instr(input string tag, input logic [2:0] stat, input logic [3:0] icode,
                            input logic [63:0] vale, input logic [63:0] vala,
                            input int d_r, input int d_v, input int n_stall,
                            input logic [63:0] rdata, input logic err);
      bit          rd, wr, acc, oob, tmo, fin, accepted, unstable;
      logic [63:0] a, exp_valm;
      logic [2:0]  exp_stat;
      int          need, exp_busy, exp_req, exp_acc;
      int          cyc, busy_n, req_n, acc_n, req_cyc, post, stall_left;

      // Reference: what the instruction should do, from the architectural rules
      rd  = (stat == SAOK) && (icode inside {IMRMOVQ, IPOPQ, IRET});
      wr  = (stat == SAOK) && (icode inside {IRMMOVQ, IPUSHQ, ICALL});
      acc = rd || wr;
      a   = (icode inside {IPOPQ, IRET}) ? vala : vale;
      oob = acc && (a > 64'(MEM_BYTES - 8));
      need = d_r + d_v + 1;
      tmo  = need > TIMEOUT;
      exp_busy = !acc ? 0 : oob ? 1 : 1 + (tmo ? TIMEOUT : need);
      exp_req  = (acc && !oob) ? ((d_r + 1 < TIMEOUT) ? d_r + 1 : TIMEOUT) : 0;
      exp_acc  = (acc && !oob && d_r < TIMEOUT) ? 1 : 0;
      exp_stat = !acc ? stat : (oob || tmo || err) ? SADR : stat;
      exp_valm = (rd && !oob && !tmo) ? rdata : 64'd0;

      M_stat_i  = stat;
      M_icode_i = icode;
      M_valE_i  = vale;
      M_valA_i  = vala;
      M_stall_i = 1'b0;
      cyc = 0; busy_n = 0; req_n = 0; acc_n = 0; req_cyc = 0; post = 0;
      stall_left = n_stall; fin = 0; accepted = 0; unstable = 0;

      while (!fin && cyc < 64) begin
         // bus responder, driven just after the clock edge
         mem_ready_i  = 1'b0;
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = ~rdata;
         mem_err_i    = 1'b0;
         if (mem_req_o) begin
            req_n++;
            if (mem_addr_o !== a || mem_we_o !== wr || (wr && mem_wdata_o !== vala)) unstable = 1;
         end
         if (!accepted && mem_req_o) begin
            if (req_cyc == d_r) begin
               mem_ready_i = 1'b1;
               accepted = 1;
               acc_n++;
               post = 0;
            end else begin
               req_cyc++;
            end
         end else if (accepted) begin
            post++;
         end
         if (accepted && post == d_v) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rdata;
            mem_err_i    = err;
         end
         @(negedge clk_i);
         if (m_busy_o) begin
            busy_n++;
            M_stall_i = 1'b1;
         end else begin
            chk({tag, ":stat"}, 64'(m_stat_o), 64'(exp_stat));
            if (!err) chk({tag, ":valM"}, m_valM_o, exp_valm);
            if (stall_left > 0) begin
               stall_left--;
               M_stall_i = 1'b1;
            end else begin
               M_stall_i = 1'b0;
               fin = 1;
            end
         end
         @(posedge clk_i);
         #1;
         cyc++;
      end
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
      M_stall_i    = 1'b0;

      chk({tag, ":left_M"}, 64'(fin), 64'd1);
      chk({tag, ":busy_cycles"}, 64'(busy_n), 64'(exp_busy));
      chk({tag, ":req_cycles"}, 64'(req_n), 64'(exp_req));
      chk({tag, ":accepts"}, 64'(acc_n), 64'(exp_acc));
      chk({tag, ":req_stable"}, 64'(unstable), 64'd0);
   endtask

   initial begin
      rst_i        = 1'b1;
      M_stat_i     = SAOK;
      M_icode_i    = IMRMOVQ;
      M_valE_i     = 64'h100;
      M_valA_i     = 64'h0;
      M_stall_i    = 1'b0;
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;

      // Reset state
      @(negedge clk_i);
      chk("rst:busy", 64'(m_busy_o), 64'd0);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      chk("rst:req", 64'(mem_req_o), 64'd0);
      chk("rst:we", 64'(mem_we_o), 64'd0);
      chk("rst:addr", mem_addr_o, 64'd0);
      chk("rst:wdata", mem_wdata_o, 64'd0);
      rst_i     = 1'b0;
      M_icode_i = INOP;
      @(negedge clk_i);
      chk("rst:valM", m_valM_o, 64'd0);
      chk("rst:nop_busy", 64'(m_busy_o), 64'd0);
      @(posedge clk_i); #1;

      // Test 1: best-case load
      run_instr("t1", SAOK, IMRMOVQ, 64'h100, 64'h0, 0, 1, 0, 64'hDEADBEEF, 1'b0);
      // Test 2: push with ready held off three cycles, response in the accept cycle
      run_instr("t2", SAOK, IPUSHQ, 64'h1F8, 64'h55, 3, 0, 0, 64'h1234, 1'b0);
      // Test 3: load straddling the top of memory
      run_instr("t3", SAOK, IMRMOVQ, 64'hFFFC, 64'h0, 0, 0, 0, 64'h1, 1'b0);
      // Test 4: pop that times out; the late rvalid lands during the stalled DONE
      run_instr("t4", SAOK, IPOPQ, 64'h0, 64'h2000, 0, 5, 2, 64'hBAD, 1'b0);
      // Test 5: DONE held two cycles, then a fresh access
      run_instr("t5a", SAOK, IMRMOVQ, 64'h300, 64'h0, 1, 1, 2, 64'hCAFE, 1'b0);
      run_instr("t5b", SAOK, ICALL, 64'h400, 64'h77, 0, 1, 0, 64'h0, 1'b0);
      // Address boundaries and other access shapes
      run_instr("edge_last_ok", SAOK, IRMMOVQ, 64'hFFF8, 64'hA5, 0, 0, 0, 64'h0, 1'b0);
      run_instr("edge_first_bad", SAOK, IRET, 64'h0, 64'hFFF9, 0, 0, 0, 64'h9, 1'b0);
      run_instr("edge_wrap", SAOK, IMRMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 0, 0, 64'h9, 1'b0);
      run_instr("bus_err", SAOK, IPOPQ, 64'h0, 64'h80, 1, 1, 0, 64'h5, 1'b1);
      run_instr("no_ready", SAOK, IRMMOVQ, 64'h80, 64'h3, 9, 0, 1, 64'h0, 1'b0);
      run_instr("bad_stat", SINS, IMRMOVQ, 64'h80, 64'h0, 0, 0, 0, 64'h0, 1'b0);

      // Test 6: reset while waiting for the response
      M_stat_i  = SAOK;
      M_icode_i = IMRMOVQ;
      M_valE_i  = 64'h200;
      @(posedge clk_i); #1;
      mem_ready_i = 1'b1;
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0;
      rst_i       = 1'b1;
      @(negedge clk_i);
      chk("t6:busy_in_rst", 64'(m_busy_o), 64'd0);
      @(posedge clk_i); #1;
      chk("t6:req_after_rst", 64'(mem_req_o), 64'd0);
      rst_i        = 1'b0;
      M_icode_i    = INOP;
      mem_rvalid_i = 1'b1;
      mem_err_i    = 1'b1;
      mem_rdata_i  = 64'hFFFF;
      @(negedge clk_i);
      chk("t6:nop_busy", 64'(m_busy_o), 64'd0);
      chk("t6:nop_stat", 64'(m_stat_o), 64'(SAOK));
      chk("t6:nop_valM", m_valM_o, 64'd0);
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
      run_instr("t6:after", SAOK, IMRMOVQ, 64'h208, 64'h0, 0, 0, 0, 64'h4242, 1'b0);

      // Randomized instruction stream
      for (int i = 0; i < 80; i++) begin
         logic [2:0]  st;
         logic [3:0]  ic;
         logic [63:0] ve, va;
         int          sel;
         st  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
         ic  = 4'($urandom_range(0, 11));
         sel = $urandom_range(0, 7);
         ve  = (sel < 6) ? 64'($urandom_range(0, MEM_BYTES - 8))
             : (sel == 6) ? 64'($urandom_range(MEM_BYTES - 7, MEM_BYTES + 8))
             : {32'($urandom), 32'($urandom)};
         va  = ($urandom_range(0, 3) != 0) ? 64'($urandom_range(0, MEM_BYTES - 8))
             : {32'($urandom), 32'($urandom)};
         run_instr($sformatf("rnd%0d", i), st, ic, ve, va,
                   $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 2),
                   {32'($urandom), 32'($urandom)}, ($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
